ddr_note_scheduler: RTL
=======================

DDR_NOTE_SCHEDULER -- requirements
Module: ddr_note_scheduler

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset; ports are clk and rst_n.
REQ-002 SHALL provide these parameters, one per line as name, default, meaning:
- PATTERN_LEN, 64, number of pattern ROM entries.
- ADDR_W, 6, ROM address width.
- COMBO_W, 8, combo counter width.
- SCORE_W, 12, score counter width.
- BONUS_THRESH, 10, combo value at or above which a hit earns the bonus.
REQ-003 SHALL provide these ports, one per line as name, direction, width, meaning:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- game_state  in  STATE_BITS+1  STATE_RESET, STATE_PAUSE or STATE_GAME from the game state generator.
- beat_tick  in  1  one-cycle beat strobe.
- lane_btn  in  4  debounced lane buttons, level-sensitive.
- rom_addr  out  ADDR_W  pattern ROM address.
- rom_data  in  4  lane mask returned one cycle after rom_addr.
- lane_pending  out  4  notes awaiting a hit.
- combo  out  COMBO_W  current combo.
- max_combo  out  COMBO_W  best combo.
- score  out  SCORE_W  score.
- hit_pulse  out  1  one-cycle hit strobe.
- miss_pulse  out  1  one-cycle miss strobe.

Function
REQ-004 SHALL implement FSM IDLE, RUN, FETCH.
- IDLE to RUN when game_state==STATE_GAME.
- RUN to FETCH on beat_tick.
- FETCH to RUN unconditionally, or to IDLE if game_state!=STATE_GAME.
- RUN to IDLE when game_state!=STATE_GAME.
REQ-005 SHALL, in IDLE with game_state==STATE_RESET, clear rom_addr, lane_pending, combo, max_combo and score next cycle.
REQ-006 SHALL freeze all registers while in IDLE with game_state==STATE_PAUSE; beat_tick and lane_btn edges are ignored.
REQ-007 SHALL present rom_addr as the current pattern pointer; in FETCH, latch lane_pending<=rom_data and advance the pointer, wrapping from PATTERN_LEN-1 to 0.
REQ-008 SHALL, in FETCH, raise miss_pulse and zero combo if any pending bit survives hit processing of that same cycle (note expiry); only one miss per FETCH regardless of lane count.
REQ-009 SHALL detect lane_btn rising edges in RUN and FETCH, evaluated against lane_pending as registered at the start of the cycle.
REQ-010 SHALL treat an edge on a pending lane as a hit:
- clear that bit;
- raise hit_pulse;
- increment combo;
- add score per REQ-018.
REQ-011 SHALL treat an edge on a non-pending lane as a miss: raise miss_pulse and zero combo; miss dominates if hit and miss coincide in one cycle.
REQ-012 SHALL count multiple simultaneous hit edges in one cycle as one hit event (combo +1).
REQ-013 SHALL saturate combo and score at all-ones; max_combo <= combo whenever combo exceeds it, one cycle later.
REQ-014 SHALL drive hit_pulse and miss_pulse for exactly one cycle and registered (one-cycle latency from edge).
REQ-015 SHALL ignore beat_tick outside RUN; a beat_tick during FETCH is dropped.

Reset
REQ-016 SHALL, on rst_n low, asynchronously force:
- FSM to IDLE;
- rom_addr, lane_pending, combo, max_combo, score, hit_pulse and miss_pulse to 0;
- edge-detect history to 0.
REQ-017 SHALL abandon any FETCH in progress on reset; no miss is reported.

Configuration
REQ-018 SHALL honour macro DDR_COMBO_BONUS_EN:
- defined: a hit adds 2 when the pre-hit combo >= BONUS_THRESH, else 1;
- undefined: every hit adds 1 and BONUS_THRESH is unused.

Structure
REQ-019 SHALL take STATE_BITS, STATE_RESET, STATE_PAUSE, STATE_GAME and NUM_LANES(=4) from the shared ddr_definitions.v; FSM encodings are local.
REQ-020 SHALL instantiate one sub-module ddr_edge_detect, a per-lane rising-edge detector with reset history 0.

Verification
REQ-021 SHALL cover these directed scenarios:
- Reset then game_state=GAME, beat_tick, rom_data=4'b0101 -> lane_pending=0101 and rom_addr=1 one cycle after FETCH.
- Pending 0101, press lanes 0 and 2 together -> single hit_pulse, combo 0->1, score +1, lane_pending=0000.
- Pending 0001 unhit, next beat_tick -> miss_pulse in FETCH cycle, combo=0, max_combo retains prior value.
- Edge on lane 3 with pending 0001 -> miss_pulse, combo=0, lane_pending stays 0001.
- Pointer at 63 and FETCH -> rom_addr=0; game_state=PAUSE mid-RUN with beat_tick and presses -> no change; GAME resumes from same pointer.
- DDR_COMBO_BONUS_EN defined, combo=10, hit -> score +2 and combo=11; undefined -> score +1. rst_n low mid-FETCH -> all outputs 0 immediately.

Source files
------------

// File: rtl/ddr_note_scheduler_pkg.sv
// Shared game definitions for the note scheduler (game-state encoding, lane count),
// mirroring the values of the game's common ddr_definitions.
package ddr_note_scheduler_pkg;

  localparam int STATE_BITS = 1;
  localparam logic [STATE_BITS:0] STATE_RESET = 2'd0;
  localparam logic [STATE_BITS:0] STATE_PAUSE = 2'd1;
  localparam logic [STATE_BITS:0] STATE_GAME  = 2'd2;
  localparam int NUM_LANES = 4;

endpackage

// File: rtl/ddr_edge_detect.sv
// Per-lane rising-edge detector; history clears to 0 on reset and holds while en is low.
module ddr_edge_detect
  import ddr_note_scheduler_pkg::*;
#(
  parameter int WIDTH = NUM_LANES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = en ? sig : hist_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= hist_d;
  end

  assign rise = sig & ~hist_q;

endmodule

// File: rtl/ddr_note_scheduler.sv
// Note scheduler: fetches lane masks from the pattern ROM on each beat and scores button hits.
// Define DDR_COMBO_BONUS_EN to make hits at or above BONUS_THRESH combo score 2 instead of 1.
module ddr_note_scheduler
  import ddr_note_scheduler_pkg::*;
#(
  parameter int PATTERN_LEN  = 64,
  parameter int ADDR_W       = 6,
  parameter int COMBO_W      = 8,
  parameter int SCORE_W      = 12,
  parameter int BONUS_THRESH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [STATE_BITS:0]     game_state,
  input  logic                    beat_tick,
  input  logic [NUM_LANES-1:0]    lane_btn,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NUM_LANES-1:0]    rom_data,
  output logic [NUM_LANES-1:0]    lane_pending,
  output logic [COMBO_W-1:0]      combo,
  output logic [COMBO_W-1:0]      max_combo,
  output logic [SCORE_W-1:0]      score,
  output logic                    hit_pulse,
  output logic                    miss_pulse
);

`ifdef DDR_COMBO_BONUS_EN
  localparam logic BONUS_EN = 1'b1;
`else
  localparam logic BONUS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FETCH} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_LANES-1:0] pend_q, pend_d;
  logic [COMBO_W-1:0]   combo_q, combo_d;
  logic [COMBO_W-1:0]   max_combo_q, max_combo_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;

  logic                 in_game, frozen, miss_ev;
  logic [NUM_LANES-1:0] rise, ev, hits, bad, left;
  logic [1:0]           score_inc;
  logic [SCORE_W:0]     score_sum;

  assign in_game = (game_state == STATE_GAME);
  assign frozen  = (state_q == S_IDLE) && (game_state == STATE_PAUSE);

  ddr_edge_detect #(.WIDTH(NUM_LANES)) u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (!frozen),
    .sig  (lane_btn),
    .rise (rise)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pend_d      = pend_q;
    combo_d     = combo_q;
    score_d     = score_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    max_combo_d = (!frozen && (combo_q > max_combo_q)) ? combo_q : max_combo_q;

    // Presses only count while the game is actually running; a pause request drops them.
    ev        = ((state_q != S_IDLE) && in_game) ? rise : '0;
    hits      = ev & pend_q;
    bad       = ev & ~pend_q;
    left      = pend_q & ~hits;
    miss_ev   = |bad;
    score_inc = 2'd1 + {1'b0, BONUS_EN && (combo_q >= COMBO_W'(BONUS_THRESH))};
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(score_inc);

    case (state_q)
      S_IDLE: begin
        if (game_state == STATE_RESET) begin
          ptr_d       = '0;
          pend_d      = '0;
          combo_d     = '0;
          max_combo_d = '0;
          score_d     = '0;
        end
        if (in_game) state_d = S_RUN;
      end
      S_RUN, S_FETCH: begin
        pend_d = left;
        if (state_q == S_FETCH) begin
          // Anything still pending after this cycle's hits has expired.
          miss_ev = miss_ev | (|left);
          pend_d  = rom_data;
          ptr_d   = (ptr_q == ADDR_W'(PATTERN_LEN-1)) ? '0 : ptr_q + ADDR_W'(1);
        end
        if (miss_ev) begin
          combo_d = '0;
          miss_d  = 1'b1;
        end else if (|hits) begin
          hit_d   = 1'b1;
          combo_d = (&combo_q) ? combo_q : combo_q + COMBO_W'(1);
          score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
        if (!in_game)                           state_d = S_IDLE;
        else if (state_q == S_RUN && beat_tick) state_d = S_FETCH;
        else                                    state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      pend_q      <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
      score_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
      score_q     <= score_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign rom_addr     = ptr_q;
  assign lane_pending = pend_q;
  assign combo        = combo_q;
  assign max_combo    = max_combo_q;
  assign score        = score_q;
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;

endmodule
